divider_arbiter: RTL

Round-robin arbiter and sequencer that shares one iterative divider among N_req requesters. It sits between client blocks and the divider datapath, which uses a Start/Ready/Error protocol. The block screens operands: divide-by-zero and zero-dividend requests are answered locally and never reach the divider. It issues the remaining requests one at a time, captures quotient and remainder, and recovers the divider from Error or a hang by pulsing its reset.

---
 rtl/divider_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one iterative divider among N_req clients,
// answering zero operands locally and recovering the divider from Error or a hang.
module divider_arbiter #(
  parameter int N_req   = 4,
  parameter int L_divn  = 8,
  parameter int L_divr  = 4,
  parameter int Timeout = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_req-1:0]          req,
  input  logic [N_req*L_divn-1:0]   dividend_in,
  input  logic [N_req*L_divr-1:0]   divisor_in,
  output logic [N_req-1:0]          done,
  output logic [L_divn-1:0]         quotient,
  output logic [L_divn-1:0]         remainder,
  output logic                      err,
  output logic                      busy,
  output logic [L_divn-1:0]         div_word1,
  output logic [L_divr-1:0]         div_word2,
  output logic                      div_start,
  output logic                      div_reset,
  input  logic [L_divn-1:0]         div_quotient,
  input  logic [L_divn-1:0]         div_remainder,
  input  logic                      div_ready,
  input  logic                      div_error
);

  localparam int PW = (N_req > 1) ? $clog2(N_req) : 1;
  localparam int CW = (Timeout > 1) ? $clog2(Timeout) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, FAULT} state_e;

  state_e              state_q;
  logic [PW-1:0]       rrPtr_q;
  logic [PW-1:0]       grant_q;
  logic [L_divn-1:0]   word1_q;
  logic [L_divr-1:0]   word2_q;
  logic [CW-1:0]       count_q;
  logic [L_divn-1:0]   quot_q;
  logic [L_divn-1:0]   rem_q;
  logic                err_q;
  logic                start_q;
  logic [N_req-1:0]    done_q;

  logic                hit_d;
  logic [PW-1:0]       grant_d;
  logic [PW-1:0]       rrPtr_d;
  logic [L_divn-1:0]   selDivn_d;
  logic [L_divr-1:0]   selDivr_d;
  int                  idx;

  // Search starts at the round-robin pointer so the last-served client goes to the back.
  always_comb begin
    hit_d   = 1'b0;
    grant_d = '0;
    idx     = 0;
    for (int i = 0; i < N_req; i++) begin
      idx = (int'(rrPtr_q) + i) % N_req;
      if (!hit_d && req[PW'(idx)]) begin
        hit_d   = 1'b1;
        grant_d = PW'(idx);
      end
    end
    selDivn_d = dividend_in[grant_d*L_divn +: L_divn];
    selDivr_d = divisor_in[grant_d*L_divr +: L_divr];
    rrPtr_d   = (grant_q == PW'(N_req - 1)) ? '0 : grant_q + PW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rrPtr_q <= '0;
      grant_q <= '0;
      word1_q <= '0;
      word2_q <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      done_q  <= '0;
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          if (hit_d) begin
            grant_q <= grant_d;
            word1_q <= selDivn_d;
            word2_q <= selDivr_d;
            if (selDivr_d == '0) begin
              quot_q  <= '0;
              rem_q   <= '0;
              err_q   <= 1'b1;
              done_q  <= N_req'(1) << grant_d;
              state_q <= RESP;
            end else if (selDivn_d == '0) begin
              quot_q  <= '0;
              rem_q   <= '0;
              err_q   <= 1'b0;
              done_q  <= N_req'(1) << grant_d;
              state_q <= RESP;
            end else begin
              start_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          count_q <= '0;
          state_q <= WAIT;
        end
        // Error outranks Ready; the timeout only fires if neither shows up in time.
        WAIT: begin
          if (div_error) begin
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b1;
            done_q  <= N_req'(1) << grant_q;
            state_q <= FAULT;
          end else if (div_ready) begin
            quot_q  <= div_quotient;
            rem_q   <= div_remainder;
            err_q   <= 1'b0;
            done_q  <= N_req'(1) << grant_q;
            state_q <= RESP;
          end else if (count_q == CW'(Timeout - 1)) begin
            quot_q  <= '0;
            rem_q   <= '0;
            err_q   <= 1'b1;
            done_q  <= N_req'(1) << grant_q;
            state_q <= FAULT;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        RESP, FAULT: begin
          rrPtr_q <= rrPtr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign div_start = start_q;
  assign div_word1 = (state_q == ISSUE || state_q == WAIT) ? word1_q : '0;
  assign div_word2 = (state_q == ISSUE || state_q == WAIT) ? word2_q : '0;
  assign div_reset = reset | (state_q == FAULT);

endmodule
